// File: rtl/servo_pkg.sv
// Shared defaults and width arithmetic for the multi-channel servo PWM block.
package servo_pkg;

  localparam int SERVO_PERIOD_US = 20000;
  localparam int SERVO_MIN_US    = 1000;
  localparam int SERVO_MAX_US    = 2000;
  localparam int SERVO_CLK_DIV   = 100;

  function automatic int clamp_width(input int width, input int lo, input int hi);
    if (width < lo) return lo;
    if (width > hi) return hi;
    return width;
  endfunction

  // Next active width: jump straight to target, or move by at most step.
  function automatic int slew_step(input int active, input int target, input int step);
    if (step == 0) return target;
    if (target > active + step) return active + step;
    if (target + step < active) return active - step;
    return target;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: clamped target, frame-synchronous active width and output flop.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int CNT_W     = 15,
  parameter int MIN_US    = SERVO_MIN_US,
  parameter int MAX_US    = SERVO_MAX_US,
  parameter int SLEW_STEP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr,
  input  logic [CNT_W-1:0] data,
  input  logic             boundary,
  input  logic [CNT_W-1:0] cntr,
  output logic             pwm
);

  localparam int CENTER = (MIN_US + MAX_US) / 2;

  logic [CNT_W-1:0] target_reg;
  logic [CNT_W-1:0] active_reg;
  logic             pwm_reg;

  // Target and active are separate so a write never disturbs the frame in flight;
  // the boundary update reads the target as it stood before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_reg <= CNT_W'(CENTER);
      active_reg <= CNT_W'(CENTER);
      pwm_reg    <= 1'b0;
    end else begin
      if (wr) begin
        target_reg <= CNT_W'(clamp_width(int'(data), MIN_US, MAX_US));
      end
      if (boundary) begin
        active_reg <= CNT_W'(slew_step(int'(active_reg), int'(target_reg), SLEW_STEP));
      end
      pwm_reg <= enable && (cntr < active_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: microsecond prescaler, frame counter, write decode
// and one servo_pwm_channel per output pin.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CLK_DIV     = SERVO_CLK_DIV,
  parameter int PERIOD_US   = SERVO_PERIOD_US,
  parameter int MIN_US      = SERVO_MIN_US,
  parameter int MAX_US      = SERVO_MAX_US,
  parameter int SLEW_STEP   = 0,
  localparam int CNT_W      = $clog2(PERIOD_US),
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  output logic              wr_err,
  output logic              frame_start,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  generate
    if (MIN_US > MAX_US || MAX_US >= PERIOD_US || CLK_DIV < 1) begin : g_bad_params
      $error("servo_pwm_multi: need MIN_US <= MAX_US < PERIOD_US and CLK_DIV >= 1");
    end
  endgenerate

  logic [PS_W-1:0]  prescaler_reg;
  logic [CNT_W-1:0] cntr_reg;
  logic             frame_start_reg;
  logic             wr_err_reg;
  logic             tick;
  logic             boundary;
  logic [NUM_CH-1:0] ch_wr;

  assign tick     = enable && (prescaler_reg == PS_W'(CLK_DIV - 1));
  assign boundary = tick && (cntr_reg == CNT_W'(PERIOD_US - 1));

  // With enable low both counters sit at zero, so re-enabling starts a clean frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg   <= '0;
      cntr_reg        <= '0;
      frame_start_reg <= 1'b0;
      wr_err_reg      <= 1'b0;
    end else begin
      frame_start_reg <= boundary;
      wr_err_reg      <= wr_en && (int'(wr_ch) >= NUM_CH);
      if (!enable) begin
        prescaler_reg <= '0;
        cntr_reg      <= '0;
      end else if (tick) begin
        prescaler_reg <= '0;
        cntr_reg      <= boundary ? '0 : cntr_reg + CNT_W'(1);
      end else begin
        prescaler_reg <= prescaler_reg + PS_W'(1);
      end
    end
  end

  assign frame_start = frame_start_reg;
  assign wr_err      = wr_err_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_wr[gi] = wr_en && (int'(wr_ch) == gi);

    servo_pwm_channel #(
      .CNT_W    (CNT_W),
      .MIN_US   (MIN_US),
      .MAX_US   (MAX_US),
      .SLEW_STEP(SLEW_STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .wr      (ch_wr[gi]),
      .data    (wr_data),
      .boundary(boundary),
      .cntr    (cntr_reg),
      .pwm     (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (no slew / slew 2) on shared stimulus,
// checked every cycle against a frame-position model plus literal pulse widths.
module tb_servo_pwm_multi;

  localparam int NUM_CH    = 3;
  localparam int CLK_DIV   = 2;
  localparam int PERIOD_US = 50;
  localparam int MIN_US    = 10;
  localparam int MAX_US    = 20;
  localparam int CNT_W     = $clog2(PERIOD_US);
  localparam int CH_W      = 2;
  localparam int FRAME_CLK = CLK_DIV * PERIOD_US;
  localparam int CENTER    = (MIN_US + MAX_US) / 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] pwm_a, pwm_b;
  logic              fs_a, fs_b, err_a, err_b;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_STEP(0)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .wr_err(err_a), .frame_start(fs_a), .pwm_out(pwm_a)
  );

  servo_pwm_multi #(
    .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .PERIOD_US(PERIOD_US),
    .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_STEP(2)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_data(wr_data), .wr_err(err_b), .frame_start(fs_b), .pwm_out(pwm_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pos = clocks elapsed in the current frame; the running width in us is m_pos / CLK_DIV.
  bit                model_ok = 1'b0;
  int                m_pos = 0;
  int                m_tgt[2][NUM_CH];
  int                m_act[2][NUM_CH];
  logic [NUM_CH-1:0] exp_pwm[2];
  logic              exp_fs, exp_err;

  function automatic int model_clamp(input int w);
    return (w < MIN_US) ? MIN_US : ((w > MAX_US) ? MAX_US : w);
  endfunction

  function automatic int model_move(input int a, input int t, input int s);
    int d;
    d = t - a;
    if (s != 0 && d > s) d = s;
    if (s != 0 && d < -s) d = -s;
    return a + d;
  endfunction

  always @(posedge clk) begin
    bit bnd;
    if (rst) begin
      model_ok = 1'b1;
      m_pos = 0;
      exp_fs = 1'b0;
      exp_err = 1'b0;
      for (int d = 0; d < 2; d++) begin
        exp_pwm[d] = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          m_tgt[d][i] = CENTER;
          m_act[d][i] = CENTER;
        end
      end
    end else begin
      bnd = enable && (m_pos == FRAME_CLK - 1);
      exp_fs = bnd;
      exp_err = wr_en && (int'(wr_ch) >= NUM_CH);
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NUM_CH; i++) begin
          exp_pwm[d][i] = enable && ((m_pos / CLK_DIV) < m_act[d][i]);
          if (bnd) m_act[d][i] = model_move(m_act[d][i], m_tgt[d][i], (d == 0) ? 0 : 2);
        end
        if (wr_en && int'(wr_ch) < NUM_CH) m_tgt[d][wr_ch] = model_clamp(int'(wr_data));
      end
      m_pos = (enable && !bnd) ? m_pos + 1 : 0;
    end
  end

  // ---------------- compare + pulse-width monitor ----------------
  int hi_cnt[2][NUM_CH];
  int last_hi[2][NUM_CH];
  int frame_cnt = 0;
  int fs_last = 0;
  int fs_prev = 0;

  always @(negedge clk) begin
    cycle++;
    if (model_ok) begin
      check("pwm_a", 32'(pwm_a), 32'(exp_pwm[0]));
      check("pwm_b", 32'(pwm_b), 32'(exp_pwm[1]));
      check("frame_start_a", 32'(fs_a), 32'(exp_fs));
      check("frame_start_b", 32'(fs_b), 32'(exp_fs));
      check("wr_err_a", 32'(err_a), 32'(exp_err));
      check("wr_err_b", 32'(err_b), 32'(exp_err));
    end
    if (rst || !enable) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NUM_CH; i++) hi_cnt[d][i] = 0;
    end else begin
      if (fs_a === 1'b1) begin
        last_hi = hi_cnt;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < NUM_CH; i++) hi_cnt[d][i] = 0;
        frame_cnt++;
        fs_prev = fs_last;
        fs_last = cycle;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        hi_cnt[0][i] += (pwm_a[i] === 1'b1) ? 1 : 0;
        hi_cnt[1][i] += (pwm_b[i] === 1'b1) ? 1 : 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    int f0, k;
    f0 = frame_cnt;
    k = 0;
    while (frame_cnt == f0 && k < 3 * FRAME_CLK) begin
      tick_(1);
      k++;
    end
    check("frame_timeout", 32'(frame_cnt != f0), 32'(1));
  endtask

  task automatic do_write(input int ch, input int data);
    wr_en = 1'b1;
    wr_ch = CH_W'(ch);
    wr_data = CNT_W'(data);
    tick_(1);
    wr_en = 1'b0;
  endtask

  task automatic check_hi(input int d, input int ch, input int clocks);
    check($sformatf("hi_clk dut%0d ch%0d", d, ch), 32'(last_hi[d][ch]), 32'(clocks));
  endtask

  int exp_a_slew[5] = '{30, 40, 40, 40, 40};
  int exp_b_slew[5] = '{30, 34, 38, 40, 40};

  initial begin
    tick_(3);
    check("reset pwm_a", 32'(pwm_a), 32'(0));
    check("reset fs_a", 32'(fs_a), 32'(0));
    check("reset err_b", 32'(err_b), 32'(0));
    rst = 1'b0;
    enable = 1'b1;

    // Default 15 us pulses, 100 clk frames.
    wait_frame();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_CH; i++) check_hi(d, i, 30);
    wait_frame();
    check("frame_period", 32'(fs_last - fs_prev), 32'(FRAME_CLK));

    // Write mid-frame only affects the next frame.
    tick_(10);
    do_write(0, 18);
    wait_frame();
    check_hi(0, 0, 30);
    check_hi(1, 0, 30);
    do_write(1, 5);
    do_write(2, 30);
    wait_frame();
    check_hi(0, 0, 36); check_hi(0, 1, 30); check_hi(0, 2, 30); check_hi(1, 0, 34);

    // Out-of-range channel: one-cycle error, nothing else moves.
    do_write(3, 12);
    check("wr_err pulse", 32'(err_a), 32'(1));
    tick_(1);
    check("wr_err clear", 32'(err_a), 32'(0));
    wait_frame();
    check_hi(0, 0, 36); check_hi(0, 1, 20); check_hi(0, 2, 40);
    check_hi(1, 0, 36); check_hi(1, 1, 26); check_hi(1, 2, 34);

    // Write on the exact boundary edge: that boundary still loads the old target.
    tick_(FRAME_CLK - 1);
    do_write(0, 10);
    check_hi(0, 0, 36); check_hi(1, 1, 22); check_hi(1, 2, 38);
    wait_frame();
    check_hi(0, 0, 36); check_hi(1, 0, 36);
    wait_frame();
    check_hi(0, 0, 20); check_hi(1, 0, 32);

    // Drop enable mid-pulse, then re-enable for a full frame.
    tick_(10);
    enable = 1'b0;
    tick_(1);
    check("disable pwm_a", 32'(pwm_a), 32'(0));
    check("disable pwm_b", 32'(pwm_b), 32'(0));
    tick_(20);
    enable = 1'b1;
    wait_frame();
    check_hi(0, 0, 20); check_hi(0, 1, 20); check_hi(0, 2, 40);
    check_hi(1, 0, 28); check_hi(1, 1, 20); check_hi(1, 2, 40);

    // Reset at cntr = 7 returns everything to centre.
    tick_(14);
    rst = 1'b1;
    tick_(1);
    check("rst pwm_a", 32'(pwm_a), 32'(0));
    check("rst fs_a", 32'(fs_a), 32'(0));
    rst = 1'b0;
    wait_frame();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_CH; i++) check_hi(d, i, 30);

    // Slew: target 20 from 15 with step 2 on dut_b.
    rst = 1'b1;
    enable = 1'b0;
    tick_(1);
    rst = 1'b0;
    do_write(0, 20);
    enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_frame();
      check_hi(0, 0, exp_a_slew[f]);
      check_hi(1, 0, exp_b_slew[f]);
    end

    // Random traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else enable = ($urandom_range(0, 19) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_ch = CH_W'($urandom_range(0, 3));
      wr_data = CNT_W'($urandom_range(0, 63));
      tick_(1);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    tick_(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel servo PWM generator. Contains its own microsecond prescaler and frame counter, so it needs no external counter. Holds per-channel target pulse widths written from the SPI/decode side, clamps them to the legal servo range, and loads them glitch-free at frame boundaries with optional slew-rate limiting. Sits between the SPI command decoder and the servo output pins.

Parameters:
NUM_CH, 4, number of servo channels
CLK_DIV, 100, clk cycles per 1 us tick (100 MHz clk)
PERIOD_US, 20000, frame length in ticks (20 ms, 50 Hz)
MIN_US, 1000, minimum pulse width in ticks
MAX_US, 2000, maximum pulse width in ticks
SLEW_STEP, 0, maximum change of the active width per frame in ticks; 0 = unlimited
(derived) CNT_W = $clog2(PERIOD_US), CH_W = max(1, $clog2(NUM_CH)), CENTER = (MIN_US+MAX_US)/2

Ports:
clk  in  1  system clock; the block uses one clock
rst  in  1  reset, synchronous, active-high
enable  in  1  1 = generate pulses; 0 = outputs low, counters held
wr_en  in  1  single-cycle write strobe
wr_ch  in  CH_W  channel index of the write
wr_data  in  CNT_W  requested pulse width in us
wr_err  out  1  one-cycle pulse when wr_ch >= NUM_CH
frame_start  out  1  one-cycle pulse at every frame boundary
pwm_out  out  NUM_CH  servo pulse outputs, registered

Behaviour:
- Reset, one edge with rst high: prescaler = 0, cntr = 0, target[i] = active[i] = CENTER, pwm_out = 0, frame_start = 0, wr_err = 0. Reset mid-frame or mid-pulse takes effect on the next edge. rst has priority over every other input.
- Prescaler counts 0..CLK_DIV-1 while enable = 1. tick = enable and (prescaler == CLK_DIV-1).
- cntr increments on tick. Frame boundary = tick and cntr == PERIOD_US-1. At the boundary: cntr <= 0, frame_start <= 1 for one cycle, and every active[i] is updated.
- Active update:
  - SLEW_STEP == 0: active <= target.
  - Otherwise: active moves toward target by min(|target-active|, SLEW_STEP).
  - The update uses the target value held before this edge.
- Write path:
  - On wr_en with wr_ch < NUM_CH: target[wr_ch] <= clamp(wr_data, MIN_US, MAX_US).
  - On wr_en with wr_ch >= NUM_CH: no state change, and wr_err = 1 on the next cycle.
  - A write never alters the frame in progress.
- Write on the same cycle as a frame boundary: the boundary loads the old target. The new value becomes effective at the following boundary (or later with slew).
- Output: pwm_out[i] <= enable and (cntr < active[i]). This is a one-clk register after cntr/active. High time per frame = active[i] ticks exactly.
- enable = 0: prescaler and cntr are cleared to 0 on each edge, pwm_out <= 0, no frame_start, targets remain writable, active is frozen.
- On the first edge with enable = 1 a fresh frame begins at cntr = 0 with the frozen active values. No boundary pulse is generated for this start.
- Comparison is unsigned with width CNT_W. Parameter legality, checked by elaboration assertions: MIN_US <= MAX_US < PERIOD_US, CLK_DIV >= 1.

Decomposition:
- Package servo_pkg:
  - default constants (SERVO_PERIOD_US, SERVO_MIN_US, SERVO_MAX_US, SERVO_CLK_DIV)
  - function clamp_width
  - function slew_step (next active given active, target, step)
- Sub-module servo_pwm_channel, instantiated NUM_CH times via generate:
  - holds target/active registers, the slew update and the compare/output flop
  - inputs: wr, data, boundary, cntr, enable
- The top level holds the prescaler, frame counter, write decode and wr_err.

Test Plan:
All scenarios use CLK_DIV=2, PERIOD_US=50, MIN_US=10, MAX_US=20, NUM_CH=2 unless stated.
1. Reset, then enable=1 -> frame_start every 100 clk; both pwm_out high 15 ticks (30 clk) per frame, beginning 1 clk after cntr=0.
2. Write ch0=18 at cntr=5 -> current frame ch0 high 15 ticks, next frame 18 ticks; ch1 stays 15.
3. Write ch1=5 -> 10 ticks high; write ch1=30 -> 20 ticks high (clamped).
4. wr_en with wr_ch=3 (CH_W=1 truncation disabled; use NUM_CH=3, CH_W=2) -> wr_err high exactly one cycle, no pwm change. Separately, write on the exact boundary cycle -> old value used for that frame.
5. SLEW_STEP=2, ch0 target 20 from 15 -> successive frames 17, 19, 20, 20 ticks.
6. enable dropped mid-pulse -> pwm_out 0 on next edge, cntr held 0; re-enable -> full pulse at current active. Assert rst at cntr=7 -> all outputs 0, widths back to 15 after release.
